lsu_mem_master: RTL and testbench

- Load/store unit that issues requests to the data memory, which answers them; it sits between the EX stage (address, funct3, store data) and the data memory port.
- Converts RV32I byte/halfword/word loads and stores into word-aligned bus transactions with byte enables.
- Runs a valid/ack handshake with timeout and returns sign- or zero-extended load data.
- Stalls the core while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_mem_master.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, default timeout and store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Byte enables for a store; a misaligned half/word falls back to the
    // aligned-down lanes, which matches the word-addressed memory.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    // Lane select, then extension; a misaligned half ignores addr_lo[0].
    always_comb begin
        byte_sel = 8'sd0;
        half_sel = 16'sd0;
        data     = 32'd0;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit bus master: turns RV32I loads/stores into word-aligned
// valid/ack memory transactions with byte enables and a timeout.
// Optional macro LSU_MISALIGN_EXC_EN: when defined, misaligned half/word
// accesses are rejected with err instead of being aligned down.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         funct3_q;
    logic [1:0]         addr_lo_q;
    logic               illegal;
    logic [31:0]        aligned_data;

    // Decode whether the presented request may go to the bus at all.
    always_comb begin
        illegal = 1'b0;
        if (req_we) begin
            illegal = (req_funct3 > F3_W);
        end else begin
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                      (req_funct3 == 3'd7);
        end
`ifdef LSU_MISALIGN_EXC_EN
        case (req_funct3)
            F3_H, F3_HU: if (req_addr[0]) illegal = 1'b1;
            F3_W:        if (req_addr[1:0] != 2'b00) illegal = 1'b1;
            default:     ;
        endcase
`endif
    end

    lsu_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (aligned_data)
    );

    // Transaction FSM with registered status and bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        busy <= 1'b1;
                        if (illegal) begin
                            // Rejected without touching the bus.
                            state     <= S_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            load_data <= 32'd0;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            err       <= 1'b0;
                            funct3_q  <= req_funct3;
                            addr_lo_q <= req_addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= req_we ? store_be(req_funct3, req_addr[1:0]) : 4'b1111;
                            mem_wdata <= req_we ? store_wdata(req_funct3, req_wdata) : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (!mem_we) begin
                            load_data <= aligned_data;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= S_DONE;
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    lsu_mem_master #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then withdraw it.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Load that is acked in its first REQ cycle.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rd,
                           input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'd0);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"},  {31'd0, err},  32'd0);
        check({tag, "_data"}, load_data, exp);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #12;
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ld",      load_data,        32'd0);
        check("rst_be",      {28'd0, mem_be},  32'd0);
        rst_n = 1'b1;
        tick();

        // LW at 0x10, acked in first REQ cycle.
        issue(1'b0, F3_W_tb(), 32'h10, 32'd0);
        check("lw_mem_req", {31'd0, mem_req}, 32'd1);
        check("lw_busy",    {31'd0, busy},    32'd1);
        check("lw_addr",    mem_addr,         32'h10);
        check("lw_be",      {28'd0, mem_be},  32'hF);
        check("lw_we",      {31'd0, mem_we},  32'd0);
        check("lw_nodone",  {31'd0, done},    32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack   = 1'b0;
        check("lw_done",    {31'd0, done},    32'd1);
        check("lw_err",     {31'd0, err},     32'd0);
        check("lw_data",    load_data,        32'hDEADBEEF);
        check("lw_req_off", {31'd0, mem_req}, 32'd0);
        tick();
        check("lw_pulse",   {31'd0, done},    32'd0);
        check("lw_idle",    {31'd0, busy},    32'd0);
        check("lw_hold",    load_data,        32'hDEADBEEF);

        // SB at 0x23 with three wait cycles.
        issue(1'b1, 3'd0, 32'h23, 32'h000000A5);
        check("sb_we",    {31'd0, mem_we},  32'd1);
        check("sb_addr",  mem_addr,         32'h20);
        check("sb_be",    {28'd0, mem_be},  32'h8);
        check("sb_wdata", mem_wdata,        32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sb_wait_req",  {31'd0, mem_req}, 32'd1);
            check("sb_wait_done", {31'd0, done},    32'd0);
            check("sb_wait_addr", mem_addr,         32'h20);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sb_done", {31'd0, done}, 32'd1);
        check("sb_err",  {31'd0, err},  32'd0);
        tick();

        // SH at 0x22 uses the upper half lanes.
        issue(1'b1, 3'd1, 32'h22, 32'h1234BEEF);
        check("sh_be",    {28'd0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata,       32'hBEEFBEEF);
        check("sh_addr",  mem_addr,        32'h20);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh_done", {31'd0, done}, 32'd1);
        tick();

        // Sub-word loads with extension.
        do_load("lb",  3'd0, 32'h11, 32'h12348067, 32'hFFFFFF80);
        do_load("lbu", 3'd4, 32'h11, 32'h12348067, 32'h00000080);
        do_load("lh",  3'd1, 32'h12, 32'h9ABC0000, 32'hFFFF9ABC);
        do_load("lhu", 3'd5, 32'h12, 32'h9ABC0000, 32'h00009ABC);
        do_load("lb0", 3'd0, 32'h14, 32'h0000007F, 32'h0000007F);

        // Illegal load funct3.
        issue(1'b0, 3'd3, 32'h40, 32'd0);
        check("ill_ld_req",  {31'd0, mem_req}, 32'd0);
        check("ill_ld_done", {31'd0, done},    32'd1);
        check("ill_ld_err",  {31'd0, err},     32'd1);
        tick();
        check("ill_ld_idle", {31'd0, busy},    32'd0);

        // Illegal store funct3.
        issue(1'b1, 3'd4, 32'h40, 32'd0);
        check("ill_st_req",  {31'd0, mem_req}, 32'd0);
        check("ill_st_err",  {31'd0, err},     32'd1);
        tick();

        // mem_ack while idle must not start anything.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_busy", {31'd0, busy}, 32'd0);
        check("idle_ack_done", {31'd0, done}, 32'd0);

        // Timeout: never acked.
        issue(1'b0, 3'd2, 32'h80, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("to_req",    {31'd0, mem_req}, 32'd1);
            check("to_nodone", {31'd0, done},    32'd0);
            tick();
        end
        check("to_done",   {31'd0, done},    32'd1);
        check("to_err",    {31'd0, err},     32'd1);
        check("to_data",   load_data,        32'd0);
        check("to_reqoff", {31'd0, mem_req}, 32'd0);
        tick();

        // Misaligned SW at 0x06.
        issue(1'b1, 3'd2, 32'h06, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_EXC_EN
        check("mis_req",  {31'd0, mem_req}, 32'd0);
        check("mis_done", {31'd0, done},    32'd1);
        check("mis_err",  {31'd0, err},     32'd1);
        tick();
`else
        check("mis_addr",  mem_addr,        32'h04);
        check("mis_be",    {28'd0, mem_be}, 32'hF);
        check("mis_wdata", mem_wdata,       32'hCAFEF00D);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("mis_done", {31'd0, done}, 32'd1);
        check("mis_err",  {31'd0, err},  32'd0);
        tick();
`endif

        // Reset in the middle of a request.
        issue(1'b0, 3'd2, 32'h100, 32'd0);
        check("rr_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_req",  {31'd0, mem_req}, 32'd0);
        check("rr_busy", {31'd0, busy},    32'd0);
        tick();
        check("rr_nodone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rr_nodone2", {31'd0, done}, 32'd0);
        check("rr_idle",    {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic [2:0] F3_W_tb();
        return 3'd2;
    endfunction

endmodule
